pc_ir_fetch: RTL and testbench

PC_IR_FETCH -- requirements
Module: pc_ir_fetch

---
 rtl/pc_ir_fetch.sv | 151 +++++++++++++++
 tb/tb_pc_ir_fetch.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_ir_fetch.sv
// Program counter and instruction register with a handshaked instruction
// fetch. A fetch timeout is fatal and stays latched until reset.
module pc_ir_fetch (
    input  logic        Clk,
    input  logic        reset,
    input  logic        IRWrite,
    input  logic        PCWrite,
    input  logic        PCWriteCond,
    input  logic [1:0]  PCSource,
    input  logic        Zero,
    input  logic [31:0] ALUResult,
    input  logic [31:0] ALUOut,
    input  logic [31:0] MemData,
    input  logic        MemReady,
    output logic        MemReq,
    output logic [31:0] MemAddr,
    output logic [31:0] PC,
    output logic [5:0]  Opcode,
    output logic [4:0]  Rs,
    output logic [4:0]  Rt,
    output logic [4:0]  Rd,
    output logic [5:0]  Funct,
    output logic [15:0] Imm16,
    output logic        Stall,
    output logic        InstrValid,
    output logic        FetchErr,
    output logic [15:0] InstrCount
);

    localparam int unsigned XLEN   = 32;
    localparam int unsigned WAIT_W = 4;
    localparam int unsigned CNT_W  = 16;

    localparam logic [1:0] SRC_ALU_RESULT = 2'b00;
    localparam logic [1:0] SRC_ALU_OUT    = 2'b01;
    localparam logic [1:0] SRC_JUMP       = 2'b10;
    localparam logic [1:0] SRC_HOLD       = 2'b11;

    localparam logic [WAIT_W-1:0] WAIT_MAX = '1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        ERR   = 2'd2
    } state_t;

    state_t            state;
    logic [XLEN-1:0]   IR;
    logic              pend;
    logic [1:0]        pend_src;
    logic [XLEN-1:0]   pend_val;
    logic [WAIT_W-1:0] wait_cnt;

    logic [XLEN-1:0]   jump_target_c;
    logic [XLEN-1:0]   src_val_c;
    logic              write_req_c;

    // Instruction fields are plain slices of the instruction register
    assign Opcode = IR[31:26];
    assign Rs     = IR[25:21];
    assign Rt     = IR[20:16];
    assign Rd     = IR[15:11];
    assign Funct  = IR[5:0];
    assign Imm16  = IR[15:0];

    // PC source mux and write-request qualification
    always_comb begin
        jump_target_c = {PC[31:28], IR[25:0], 2'b00};
        write_req_c   = PCWrite | (PCWriteCond & Zero);
        src_val_c     = PC;
        case (PCSource)
            SRC_ALU_RESULT: src_val_c = ALUResult;
            SRC_ALU_OUT:    src_val_c = ALUOut;
            SRC_JUMP:       src_val_c = jump_target_c;
            SRC_HOLD:       src_val_c = PC;
            default:        src_val_c = PC;
        endcase
    end

    // Fetch FSM with registered handshake/status outputs
    always_ff @(posedge Clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            PC         <= '0;
            IR         <= '0;
            pend       <= 1'b0;
            pend_src   <= SRC_HOLD;
            pend_val   <= '0;
            wait_cnt   <= '0;
            MemReq     <= 1'b0;
            MemAddr    <= '0;
            Stall      <= 1'b0;
            InstrValid <= 1'b0;
            FetchErr   <= 1'b0;
            InstrCount <= '0;
        end else begin
            InstrValid <= 1'b0;
            case (state)
                IDLE: begin
                    if (IRWrite) begin
                        // PC write requested alongside a fetch is deferred
                        // until the instruction word arrives
                        state    <= FETCH;
                        pend     <= write_req_c;
                        pend_src <= PCSource;
                        pend_val <= src_val_c;
                        wait_cnt <= '0;
                        MemReq   <= 1'b1;
                        MemAddr  <= PC;
                        Stall    <= 1'b1;
                    end else if (write_req_c && (PCSource != SRC_HOLD)) begin
                        PC <= src_val_c;
                    end
                end
                FETCH: begin
                    if (MemReady) begin
                        IR <= MemData;
                        if (pend && (pend_src != SRC_HOLD)) begin
                            PC <= pend_val;
                        end
                        pend       <= 1'b0;
                        InstrValid <= 1'b1;
                        InstrCount <= InstrCount + CNT_W'(1);
                        MemReq     <= 1'b0;
                        Stall      <= 1'b0;
                        state      <= IDLE;
                    end else if (wait_cnt == WAIT_MAX) begin
                        state    <= ERR;
                        MemReq   <= 1'b0;
                        FetchErr <= 1'b1;
                        pend     <= 1'b0;
                    end else begin
                        wait_cnt <= wait_cnt + WAIT_W'(1);
                    end
                end
                ERR: begin
                    // Terminal until reset
                    state  <= ERR;
                    MemReq <= 1'b0;
                    Stall  <= 1'b1;
                end
                default: begin
                    state  <= IDLE;
                    MemReq <= 1'b0;
                    Stall  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_ir_fetch.sv
// Self-checking bench for pc_ir_fetch: vector table for IDLE PC writes,
// scoreboard queues for fetch results, hand sequences for corner cases.
module tb_pc_ir_fetch;

    logic        Clk = 1'b0;
    logic        reset;
    logic        IRWrite, PCWrite, PCWriteCond, Zero, MemReady;
    logic [1:0]  PCSource;
    logic [31:0] ALUResult, ALUOut, MemData;
    logic        MemReq, Stall, InstrValid, FetchErr;
    logic [31:0] MemAddr, PC;
    logic [5:0]  Opcode, Funct;
    logic [4:0]  Rs, Rt, Rd;
    logic [15:0] Imm16, InstrCount;

    int checks = 0;
    int errors = 0;

    logic [31:0] m_pc, m_ir;
    logic [15:0] m_cnt;
    logic [31:0] exp_ir_q[$];
    logic [31:0] exp_pc_q[$];

    typedef struct {
        logic        pcw;
        logic        pcwc;
        logic        zero;
        logic [1:0]  src;
        logic [31:0] alur;
        logic [31:0] aluo;
        logic        mready;
        logic [31:0] exp_pc;
    } vec_t;

    vec_t vecs[7];

    pc_ir_fetch dut (
        .Clk(Clk), .reset(reset), .IRWrite(IRWrite), .PCWrite(PCWrite),
        .PCWriteCond(PCWriteCond), .PCSource(PCSource), .Zero(Zero),
        .ALUResult(ALUResult), .ALUOut(ALUOut), .MemData(MemData),
        .MemReady(MemReady), .MemReq(MemReq), .MemAddr(MemAddr), .PC(PC),
        .Opcode(Opcode), .Rs(Rs), .Rt(Rt), .Rd(Rd), .Funct(Funct),
        .Imm16(Imm16), .Stall(Stall), .InstrValid(InstrValid),
        .FetchErr(FetchErr), .InstrCount(InstrCount)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk_fields();
        chk("opcode", 32'(Opcode), 32'(m_ir[31:26]));
        chk("rs",     32'(Rs),     32'(m_ir[25:21]));
        chk("rt",     32'(Rt),     32'(m_ir[20:16]));
        chk("rd",     32'(Rd),     32'(m_ir[15:11]));
        chk("funct",  32'(Funct),  32'(m_ir[5:0]));
        chk("imm16",  32'(Imm16),  32'(m_ir[15:0]));
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_pc"},    PC, 32'h0);
        chk({tag, "_ir"},    32'(Opcode), 32'h0);
        chk({tag, "_imm"},   32'(Imm16), 32'h0);
        chk({tag, "_req"},   32'(MemReq), 32'h0);
        chk({tag, "_addr"},  MemAddr, 32'h0);
        chk({tag, "_stall"}, 32'(Stall), 32'h0);
        chk({tag, "_valid"}, 32'(InstrValid), 32'h0);
        chk({tag, "_err"},   32'(FetchErr), 32'h0);
        chk({tag, "_cnt"},   32'(InstrCount), 32'h0);
    endtask

    task automatic idle_inputs();
        IRWrite = 1'b0; PCWrite = 1'b0; PCWriteCond = 1'b0; Zero = 1'b0;
        PCSource = 2'b00; ALUResult = '0; ALUOut = '0;
        MemData = '0; MemReady = 1'b0;
    endtask

    // One fetch: request in IDLE, `delay` MemReady=0 cycles, then accept
    task automatic fetch(input logic pcw, input logic pcwc, input logic z,
                         input logic [1:0] src, input logic [31:0] alur,
                         input logic [31:0] aluo, input int delay,
                         input logic [31:0] data, input logic [31:0] exp_pc,
                         input logic poke);
        logic [31:0] e_ir, e_pc;
        IRWrite = 1'b1; PCWrite = pcw; PCWriteCond = pcwc; Zero = z;
        PCSource = src; ALUResult = alur; ALUOut = aluo;
        exp_ir_q.push_back(data);
        exp_pc_q.push_back(exp_pc);
        step();
        idle_inputs();
        for (int i = 0; i < delay; i++) begin
            chk("req_wait",   32'(MemReq), 32'h1);
            chk("addr_wait",  MemAddr, m_pc);
            chk("stall_wait", 32'(Stall), 32'h1);
            chk("pc_hold",    PC, m_pc);
            if (poke) begin
                IRWrite = 1'b1; PCWrite = 1'b1; PCSource = 2'b00;
                ALUResult = 32'hDEAD_0000;
            end
            step();
        end
        chk("req_last",  32'(MemReq), 32'h1);
        chk("addr_last", MemAddr, m_pc);
        MemReady = 1'b1; MemData = data;
        step();
        idle_inputs();
        chk("valid_pulse", 32'(InstrValid), 32'h1);
        e_ir = exp_ir_q.pop_front();
        e_pc = exp_pc_q.pop_front();
        chk("ir_fetch", {Opcode, Rs, Rt, Imm16}, e_ir);
        chk("pc_fetch", PC, e_pc);
        chk("cnt_fetch", 32'(InstrCount), 32'(16'(m_cnt + 16'd1)));
        chk("stall_done", 32'(Stall), 32'h0);
        chk("req_done", 32'(MemReq), 32'h0);
        m_ir = e_ir; m_pc = e_pc; m_cnt = 16'(m_cnt + 16'd1);
        chk_fields();
        step();
        chk("valid_drop", 32'(InstrValid), 32'h0);
    endtask

    initial begin
        // pcw pcwc zero src alur aluo mready exp_pc ; starts at PC=4, IR=0x8D090004
        vecs[0] = '{1'b0, 1'b1, 1'b0, 2'b01, 32'h0,   32'h40,       1'b0, 32'h4};
        vecs[1] = '{1'b0, 1'b1, 1'b1, 2'b01, 32'h0,   32'h40,       1'b0, 32'h40};
        vecs[2] = '{1'b1, 1'b0, 1'b0, 2'b11, 32'h123, 32'h0,        1'b0, 32'h40};
        vecs[3] = '{1'b0, 1'b0, 1'b0, 2'b00, 32'h99,  32'h0,        1'b1, 32'h40};
        vecs[4] = '{1'b1, 1'b0, 1'b0, 2'b00, 32'h100, 32'h0,        1'b0, 32'h100};
        vecs[5] = '{1'b1, 1'b0, 1'b0, 2'b10, 32'h0,   32'h0,        1'b0, 32'h0424_0010};
        vecs[6] = '{1'b1, 1'b1, 1'b0, 2'b01, 32'h0,   32'h1000_0008, 1'b0, 32'h1000_0008};

        idle_inputs();
        reset = 1'b0;
        m_pc = '0; m_ir = '0; m_cnt = '0;
        #3;
        chk_reset_vals("rst");
        @(negedge Clk);
        reset = 1'b1;

        // Basic fetch with pending PC write
        fetch(1'b1, 1'b0, 1'b0, 2'b00, 32'h4, 32'h0, 2, 32'h8D09_0004, 32'h4, 1'b0);
        chk("opcode_lw", 32'(Opcode), 32'h23);

        // IDLE PC writes from the vector table
        for (int i = 0; i < 7; i++) begin
            PCWrite = vecs[i].pcw; PCWriteCond = vecs[i].pcwc; Zero = vecs[i].zero;
            PCSource = vecs[i].src; ALUResult = vecs[i].alur; ALUOut = vecs[i].aluo;
            MemReady = vecs[i].mready; MemData = 32'hFFFF_FFFF;
            exp_pc_q.push_back(vecs[i].exp_pc);
            step();
            idle_inputs();
            m_pc = exp_pc_q.pop_front();
            chk($sformatf("vec%0d_pc", i), PC, m_pc);
            chk($sformatf("vec%0d_ir", i), {Opcode, Rs, Rt, Imm16}, m_ir);
            chk($sformatf("vec%0d_stall", i), 32'(Stall), 32'h0);
            chk($sformatf("vec%0d_valid", i), 32'(InstrValid), 32'h0);
        end

        // Minimum-latency fetch, then jump through the new IR
        fetch(1'b0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 0, 32'h0800_0010, 32'h1000_0008, 1'b0);
        PCWrite = 1'b1; PCSource = 2'b10;
        step();
        idle_inputs();
        m_pc = 32'h1000_0040;
        chk("jump_pc", PC, m_pc);

        // Deferred conditional write; PCWrite/IRWrite during FETCH ignored
        fetch(1'b0, 1'b1, 1'b1, 2'b01, 32'h0, 32'h200, 3, 32'h00A5_1820, 32'h200, 1'b1);
        chk("rd_add", 32'(Rd), 32'h3);
        chk("funct_add", 32'(Funct), 32'h20);

        // MemReady on the cycle the wait counter hits 15 still completes
        fetch(1'b1, 1'b0, 1'b0, 2'b00, 32'h300, 32'h0, 15, 32'h1234_5678, 32'h300, 1'b0);

        // Counter wrap from 0xFFFF
        force dut.InstrCount = 16'hFFFF;
        #2;
        release dut.InstrCount;
        #1;
        m_cnt = 16'hFFFF;
        chk("cnt_preset", 32'(InstrCount), 32'hFFFF);
        fetch(1'b0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 1, 32'hCAFE_F00D, 32'h300, 1'b1);
        chk("cnt_wrapped", 32'(InstrCount), 32'h0);

        // Timeout: 16 FETCH cycles without MemReady
        step();
        IRWrite = 1'b1; PCWrite = 1'b1; PCSource = 2'b00; ALUResult = 32'h55;
        step();
        idle_inputs();
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("to%0d_err", i), 32'(FetchErr), 32'h0);
            chk($sformatf("to%0d_req", i), 32'(MemReq), 32'h1);
            step();
        end
        chk("to_err", 32'(FetchErr), 32'h1);
        chk("to_req", 32'(MemReq), 32'h0);
        chk("to_stall", 32'(Stall), 32'h1);
        chk("to_pc", PC, m_pc);
        chk("to_ir", {Opcode, Rs, Rt, Imm16}, m_ir);
        IRWrite = 1'b1; PCWrite = 1'b1; MemReady = 1'b1; MemData = 32'h1111_1111;
        ALUResult = 32'h77;
        for (int i = 0; i < 3; i++) step();
        idle_inputs();
        chk("err_sticky", 32'(FetchErr), 32'h1);
        chk("err_req", 32'(MemReq), 32'h0);
        chk("err_pc", PC, m_pc);
        chk("err_ir", {Opcode, Rs, Rt, Imm16}, m_ir);
        chk("err_cnt", 32'(InstrCount), 32'(m_cnt));
        chk("err_valid", 32'(InstrValid), 32'h0);

        // Reset out of ERR
        #2 reset = 1'b0;
        #1;
        chk_reset_vals("err_rst");
        #3 reset = 1'b1;
        m_pc = '0; m_ir = '0; m_cnt = '0;

        // Reset asserted mid-FETCH abandons the request
        step();
        IRWrite = 1'b1; PCWrite = 1'b1; ALUResult = 32'h777;
        step();
        idle_inputs();
        chk("mf_req", 32'(MemReq), 32'h1);
        #2 reset = 1'b0;
        #1;
        chk_reset_vals("mf_rst");
        MemReady = 1'b1; MemData = 32'hABCD_EF01;
        #2;
        step();
        #3;
        reset = 1'b1;
        MemReady = 1'b0;
        step();
        chk_reset_vals("mf_after");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Absolute time bound
    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1);
    end

endmodule
